ms_controller: RTL and testbench
================================

MS_CONTROLLER -- requirements
Module: ms_controller

Interface
REQ-001 SHALL have parameter NREG, default 8, number of general registers driven by Rin/Rout; legal range 1..8.
REQ-002 SHALL have port CLKb  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RSTb  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Exec  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port INSTR  input  10  instruction: [9:6] opcode, [5:3] Rx, [2:0] Ry.
REQ-006 SHALL have port Rin  output  NREG  one-hot register load enables.
REQ-007 SHALL have port Rout  output  NREG  one-hot register bus-drive enables.
REQ-008 SHALL have port ExtLoad  output  1  external data drives bus.
REQ-009 SHALL have ports Ain, Gin, Gout  output  1 each  ALU stage A-load, G-load, G-drive enables.
REQ-010 SHALL have port ALUControl  output  3  ALU op code: ADD 000, SUB 001, INV 010, AND 011, OR 100, XOR 101.
REQ-011 SHALL have ports Busy, Done  output  1 each  in-progress flag; one-cycle completion strobe.

Function
REQ-012 SHALL implement states IDLE, T1, T2, T3 with a 10-bit internal instruction register IR.
REQ-013 In IDLE with Exec=1 at a clock edge, SHALL load IR<=INSTR and move to T1; Exec=0 stays IDLE.
REQ-014 SHALL ignore Exec and INSTR in T1..T3; IR stays constant until next acceptance.
REQ-015 Opcodes: 0000 LOAD, 0001 MOV, 0010 ADD, 0011 SUB, 0100 INV, 0101 AND, 0110 OR, 0111 XOR; 1000-1111 illegal.
REQ-016 Any Rx or Ry used by the opcode with value >= NREG SHALL make the instruction illegal.
REQ-017 LOAD: T1 ExtLoad=1, Rin[Rx]=1, Done=1; then IDLE.
REQ-018 MOV: T1 Rout[Ry]=1, Rin[Rx]=1, Done=1; then IDLE; Rx=Ry permitted.
REQ-019 ADD/SUB/AND/OR/XOR: T1 Rout[Rx]=1, Ain=1; T2 Rout[Ry]=1, Gin=1, ALUControl=op; T3 Gout=1, Rin[Rx]=1, Done=1; then IDLE.
REQ-020 INV: T1 Rout[Ry]=1, Gin=1, ALUControl=010; T2 Gout=1, Rin[Rx]=1, Done=1; then IDLE.
REQ-021 Illegal: T1 Done=1 with all enables 0; then IDLE.
REQ-022 Outputs SHALL be combinational decodes of state and IR only (Moore); no input-to-output paths.
REQ-023 ALUControl SHALL be 000 in every cycle Gin=0.
REQ-024 At most one Rout bit, and never Rout together with ExtLoad or Gout, SHALL be asserted per cycle (single bus driver).
REQ-025 Busy SHALL be 1 exactly in T1..T3; Done SHALL be high exactly one cycle per accepted instruction.
REQ-026 Latency from acceptance edge to Done cycle: 1 cycle LOAD/MOV/illegal, 2 INV, 3 binary ALU ops.
REQ-027 Exec held high continuously SHALL start a new instruction on the first edge in IDLE after each Done (one idle cycle between instructions).

Reset
REQ-028 RSTb=0 SHALL immediately force state IDLE, IR=0, and all outputs 0, independent of CLKb.
REQ-029 Reset asserted mid-instruction SHALL abort it with no Done; first edge after RSTb rises samples Exec in IDLE.

Configuration
REQ-030 Macro MS_CTRL_ERR_EN defined SHALL add output port Err (1 bit), high with Done in the illegal T1 cycle only, 0 under reset.
REQ-031 Without MS_CTRL_ERR_EN SHALL omit Err; illegal instructions complete as silent NOPs per REQ-021.

Verification
REQ-032 Reset then Exec=1, INSTR=0000_011_000 -> next cycle ExtLoad=1, Rin=00001000, Done=1; following cycle Busy=0.
REQ-033 INSTR=0010_001_010 (ADD R1,R2) -> T1 Rout=00000010 Ain=1; T2 Rout=00000100 Gin=1 ALUControl=000; T3 Gout=1 Rin=00000010 Done=1.
REQ-034 INSTR=0100_101_110 (INV) -> T1 Rout=01000000 Gin=1 ALUControl=010; T2 Gout=1 Rin=00100000 Done=1.
REQ-035 INSTR=1111_000_000, and NREG=4 with INSTR=0001_101_000 -> single-cycle Done, all enables 0, Err=1 when MS_CTRL_ERR_EN.
REQ-036 RSTb low during T2 of XOR with Exec toggling -> outputs 0 at once, no Done; after release, Exec=1 INSTR=0001_000_111 completes MOV in one cycle.

Source files
------------

// File: rtl/ms_controller.sv
// Multi-step datapath controller: IDLE/T1/T2/T3 sequencer with IR decode.
// Optional illegal-instruction flag output Err when MS_CTRL_ERR_EN is defined.
module ms_controller #(
    parameter int NREG = 8
) (
    input  logic            CLKb,
    input  logic            RSTb,
    input  logic            Exec,
    input  logic [9:0]      INSTR,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            ExtLoad,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic [2:0]      ALUControl,
    output logic            Busy,
    output logic            Done
`ifdef MS_CTRL_ERR_EN
    ,
    output logic            Err
`endif
);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    localparam logic [3:0] NLIM = 4'(NREG);

    state_t     state;
    logic [9:0] ir;
    logic [3:0] op;
    logic [2:0] rx, ry;
    logic       uses_ry, illegal;
    logic       is_load, is_mov, is_inv, is_bin;
    logic [2:0] alu_op;

    assign op = ir[9:6];
    assign rx = ir[5:3];
    assign ry = ir[2:0];

    function automatic logic [NREG-1:0] sel(input logic [2:0] idx);
        sel = NREG'(1) << idx;
    endfunction

    // Classify the held instruction; out-of-range registers make it illegal.
    always_comb begin
        uses_ry = !op[3] && (op != 4'b0000);
        illegal = op[3] || ({1'b0, rx} >= NLIM)
                  || (uses_ry && ({1'b0, ry} >= NLIM));
        is_load = !illegal && (op == 4'b0000);
        is_mov  = !illegal && (op == 4'b0001);
        is_inv  = !illegal && (op == 4'b0100);
        is_bin  = !illegal && !is_load && !is_mov && !is_inv;
        unique case (op)
            4'b0011: alu_op = 3'b001;
            4'b0101: alu_op = 3'b011;
            4'b0110: alu_op = 3'b100;
            4'b0111: alu_op = 3'b101;
            default: alu_op = 3'b000;
        endcase
    end

    // Sequencer: accept in IDLE, step through the per-opcode phase count.
    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            unique case (state)
                IDLE: if (Exec) begin
                    ir    <= INSTR;
                    state <= T1;
                end
                T1: state <= (is_inv || is_bin) ? T2 : IDLE;
                T2: state <= is_bin ? T3 : IDLE;
                T3: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode of state and IR into datapath enables.
    always_comb begin
        Rin        = '0;
        Rout       = '0;
        ExtLoad    = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        Gout       = 1'b0;
        ALUControl = 3'b000;
        Done       = 1'b0;
        Busy       = (state != IDLE);
        unique case (state)
            T1: begin
                unique case (1'b1)
                    illegal: Done = 1'b1;
                    is_load: begin
                        ExtLoad = 1'b1;
                        Rin     = sel(rx);
                        Done    = 1'b1;
                    end
                    is_mov: begin
                        Rout = sel(ry);
                        Rin  = sel(rx);
                        Done = 1'b1;
                    end
                    is_inv: begin
                        Rout       = sel(ry);
                        Gin        = 1'b1;
                        ALUControl = 3'b010;
                    end
                    is_bin: begin
                        Rout = sel(rx);
                        Ain  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T2: begin
                if (is_inv) begin
                    Gout = 1'b1;
                    Rin  = sel(rx);
                    Done = 1'b1;
                end else if (is_bin) begin
                    Rout       = sel(ry);
                    Gin        = 1'b1;
                    ALUControl = alu_op;
                end
            end
            T3: begin
                if (is_bin) begin
                    Gout = 1'b1;
                    Rin  = sel(rx);
                    Done = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef MS_CTRL_ERR_EN
    assign Err = (state == T1) && illegal;
`endif

endmodule

// File: tb/tb_ms_controller.sv
// Scoreboard bench for ms_controller: NREG=8 and NREG=4 instances side by side.
// Expected per-cycle output vectors are queued at issue and popped each cycle.
module tb_ms_controller;

    typedef struct packed {
        logic [7:0] rin;
        logic [7:0] rout;
        logic       extload;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [2:0] alu;
        logic       busy;
        logic       done;
        logic       err;
    } out_t;

    typedef struct packed {
        out_t e8;
        out_t e4;
    } exp_t;

    logic       CLKb, RSTb, Exec;
    logic [9:0] INSTR;

    logic [7:0] rin8, rout8;
    logic [3:0] rin4, rout4;
    logic       ext8, ain8, gin8, gout8, busy8, done8, err8;
    logic       ext4, ain4, gin4, gout4, busy4, done4, err4;
    logic [2:0] alu8, alu4;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    ms_controller #(.NREG(8)) dut8 (
        .CLKb(CLKb), .RSTb(RSTb), .Exec(Exec), .INSTR(INSTR),
        .Rin(rin8), .Rout(rout8), .ExtLoad(ext8), .Ain(ain8),
        .Gin(gin8), .Gout(gout8), .ALUControl(alu8),
        .Busy(busy8), .Done(done8)
`ifdef MS_CTRL_ERR_EN
        , .Err(err8)
`endif
    );

    ms_controller #(.NREG(4)) dut4 (
        .CLKb(CLKb), .RSTb(RSTb), .Exec(Exec), .INSTR(INSTR),
        .Rin(rin4), .Rout(rout4), .ExtLoad(ext4), .Ain(ain4),
        .Gin(gin4), .Gout(gout4), .ALUControl(alu4),
        .Busy(busy4), .Done(done4)
`ifdef MS_CTRL_ERR_EN
        , .Err(err4)
`endif
    );

`ifndef MS_CTRL_ERR_EN
    assign err8 = 1'b0;
    assign err4 = 1'b0;
`endif

    initial begin
        CLKb = 1'b0;
        forever #5 CLKb = ~CLKb;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic bad_instr(input logic [9:0] ins, input int nreg);
        int o, x, y;
        o = int'(ins[9:6]);
        x = int'(ins[5:3]);
        y = int'(ins[2:0]);
        return (o >= 8) || (x >= nreg) || (o != 0 && y >= nreg);
    endfunction

    function automatic int lat(input logic [9:0] ins, input int nreg);
        int o;
        o = int'(ins[9:6]);
        if (bad_instr(ins, nreg) || o <= 1) return 1;
        if (o == 4) return 2;
        return 3;
    endfunction

    // Reference behaviour of step s (1-based) of an instruction.
    function automatic out_t model(input logic [9:0] ins, input int s,
                                   input int nreg);
        out_t o;
        int   op, x, y;
        logic [2:0] code;
        o = '0;
        op = int'(ins[9:6]);
        x = int'(ins[5:3]);
        y = int'(ins[2:0]);
        if (s > lat(ins, nreg)) return o;
        o.busy = 1'b1;
        o.done = (s == lat(ins, nreg));
        if (bad_instr(ins, nreg)) begin
`ifdef MS_CTRL_ERR_EN
            o.err = 1'b1;
`endif
            return o;
        end
        case (op)
            2: code = 3'b000;
            3: code = 3'b001;
            5: code = 3'b011;
            6: code = 3'b100;
            default: code = 3'b101;
        endcase
        case (op)
            0: begin
                o.extload = 1'b1;
                o.rin[x]  = 1'b1;
            end
            1: begin
                o.rout[y] = 1'b1;
                o.rin[x]  = 1'b1;
            end
            4: begin
                if (s == 1) begin
                    o.rout[y] = 1'b1;
                    o.gin     = 1'b1;
                    o.alu     = 3'b010;
                end else begin
                    o.gout   = 1'b1;
                    o.rin[x] = 1'b1;
                end
            end
            default: begin
                if (s == 1) begin
                    o.rout[x] = 1'b1;
                    o.ain     = 1'b1;
                end else if (s == 2) begin
                    o.rout[y] = 1'b1;
                    o.gin     = 1'b1;
                    o.alu     = code;
                end else begin
                    o.gout   = 1'b1;
                    o.rin[x] = 1'b1;
                end
            end
        endcase
        return o;
    endfunction

    function automatic out_t obs8();
        out_t o;
        o = '{rin8, rout8, ext8, ain8, gin8, gout8, alu8, busy8, done8, err8};
        return o;
    endfunction

    function automatic out_t obs4();
        out_t o;
        o = '{{4'b0, rin4}, {4'b0, rout4}, ext4, ain4, gin4, gout4,
              alu4, busy4, done4, err4};
        return o;
    endfunction

    task automatic push_idle();
        sb.push_back('0);
    endtask

    // Queue every cycle of one instruction plus one trailing idle cycle.
    task automatic push_instr(input logic [9:0] ins, output int n);
        int l8, l4;
        exp_t e;
        l8 = lat(ins, 8);
        l4 = lat(ins, 4);
        n = ((l8 > l4) ? l8 : l4) + 1;
        for (int s = 1; s <= n; s++) begin
            e.e8 = model(ins, s, 8);
            e.e4 = model(ins, s, 4);
            sb.push_back(e);
        end
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        out_t o8, o4;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e  = sb.pop_front();
        o8 = obs8();
        o4 = obs4();
        assert (o8 === e.e8 && o4 === e.e4) else begin
            mismatched++;
            $error("FAIL %s got8=%h exp8=%h got4=%h exp4=%h",
                   tag, o8, e.e8, o4, e.e4);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLKb);
        #1;
    endtask

    // Issue one instruction; inputs are scrambled while both units are busy.
    task automatic run(input logic [9:0] ins, input string tag);
        int n;
        exp_t e;
        Exec  = 1'b1;
        INSTR = ins;
        push_instr(ins, n);
        for (int i = 0; i < n; i++) begin
            e = sb[0];
            next_cycle();
            check_now(tag);
            INSTR = 10'($urandom);
            Exec  = (e.e8.busy && !e.e8.done && e.e4.busy && !e.e4.done)
                    ? 1'($urandom) : 1'b0;
        end
        Exec = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [9:0] ins;
        int n;
        RSTb  = 1'b0;
        Exec  = 1'b0;
        INSTR = '0;
        #3;
        push_idle();
        check_now("reset");
        #19 RSTb = 1'b1;
        next_cycle();
        push_idle();
        check_now("idle");

        run(10'b0000_011_000, "load_r3");
        run(10'b0010_001_010, "add_r1_r2");
        run(10'b0100_101_110, "inv_r5_r6");
        run(10'b0011_000_011, "sub_r0_r3");
        run(10'b0101_010_001, "and");
        run(10'b0110_011_011, "or_same");
        run(10'b0111_001_000, "xor");
        run(10'b0001_010_010, "mov_same");
        run(10'b0001_111_000, "mov_r7");
        run(10'b1111_000_000, "illegal_op");
        run(10'b0001_101_000, "mov_rx_range");
        run(10'b0000_111_111, "load_r7");
        for (int k = 0; k < 16; k++) begin
            ins = {1'b0, 9'($urandom)};
            run(ins, "random");
        end

        // Exec held high: one idle cycle between back-to-back instructions.
        Exec  = 1'b1;
        INSTR = 10'b0000_011_000;
        e.e8 = model(INSTR, 1, 8);
        e.e4 = model(INSTR, 1, 4);
        sb.push_back(e);
        push_idle();
        sb.push_back(e);
        push_idle();
        next_cycle();
        check_now("held_t1a");
        next_cycle();
        check_now("held_idle");
        next_cycle();
        check_now("held_t1b");
        Exec = 1'b0;
        next_cycle();
        check_now("held_end");

        // Reset during T2 of XOR aborts with outputs cleared at once.
        Exec  = 1'b1;
        INSTR = 10'b0111_010_011;
        e.e8 = model(INSTR, 1, 8);
        e.e4 = model(INSTR, 1, 4);
        sb.push_back(e);
        e.e8 = model(INSTR, 2, 8);
        e.e4 = model(INSTR, 2, 4);
        sb.push_back(e);
        next_cycle();
        check_now("xor_t1");
        Exec = 1'b0;
        next_cycle();
        check_now("xor_t2");
        #2 RSTb = 1'b0;
        #1;
        push_idle();
        check_now("async_rst");
        for (int k = 0; k < 3; k++) begin
            Exec = ~Exec;
            next_cycle();
            push_idle();
            check_now("in_rst");
        end
        Exec = 1'b0;
        #3 RSTb = 1'b1;
        next_cycle();
        push_idle();
        check_now("post_rst");
        run(10'b0001_000_111, "mov_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
